// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset-release sequencer.
//
// Contents:
//   seqState_e  - sequencer FSM states (HOLD / RELEASE / DONE), 2-bit encoding
//   cntWidth()  - width of the shared hold/gap counter, sized so that the
//                 larger of the two terminal values fits without wrapping
package rst_seq_pkg;

  // HOLD keeps every channel asserted, RELEASE walks the channels up one by
  // one, DONE parks with everything released until a new reset arrives.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seqState_e;

  // One counter serves both the minimum-assertion window and the inter-
  // channel gap, so it has to hold whichever terminal value is larger.
  function automatic int cntWidth(input int minAssert, input int gap);
    int largest;
    largest = (minAssert > gap) ? minAssert : gap;
    return $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Reset synchronizer: asserts asynchronously, deasserts synchronously.
//
// Parameters:
//   SYNC_STAGES - number of flops in the chain (>= 2)
//
// Ports:
//   clk      in  1  destination clock, rising edge
//   rstn     in  1  raw asynchronous active-low reset
//   rst_sync out 1  high once rstn has been high for SYNC_STAGES edges;
//                   drops immediately when rstn falls
//
// Usable on its own at the top of any clock domain.
module rst_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] chain_q;

  // A constant 1 is shifted in from the bottom of the chain; the async clear
  // wipes the whole chain so the output drops without waiting for a clock,
  // while the release has to ripple through every stage first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset-release sequencer for one clock domain.
//
// After the synchronized reset (or a software request) all channels stay
// asserted for MIN_ASSERT edges, then channel 0 is released, and each further
// channel follows GAP edges after the previous one. rst_done rises with the
// last channel.
//
// Parameters:
//   NCH         - number of sequenced reset outputs (>= 1)
//   SYNC_STAGES - synchronizer depth (>= 2)
//   MIN_ASSERT  - edges of full assertion before channel 0 releases (>= 1)
//   GAP         - edges between successive channel releases (>= 1)
//
// Ports:
//   clk          in  1    sole clock, rising edge
//   rstn         in  1    asynchronous active-low reset
//   soft_rst_req in  1    synchronous request to re-run the sequence
//   rstn_out     out NCH  per-channel active-low reset, channel 0 first
//   rst_done     out 1    high once every channel is released
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 4,
  parameter int GAP         = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           soft_rst_req,
  output logic [NCH-1:0] rstn_out,
  output logic           rst_done
);

  localparam int             CW       = cntWidth(MIN_ASSERT, GAP);
  localparam logic [CW-1:0]  HOLD_END = CW'(MIN_ASSERT);
  localparam logic [CW-1:0]  GAP_END  = CW'(GAP);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [NCH-1:0] FIRST_CH = NCH'(1);

  seqState_e      state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  countInc;
  logic [NCH-1:0] outs_q, outs_d;
  logic [NCH-1:0] outsNext;
  logic [NCH:0]   outsShift;
  logic           done_q, done_d;
  logic           rstSync;

  rst_sync_cell #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .rst_sync(rstSync)
  );

  // The released channels always form a run of ones from bit 0 upward, so
  // releasing the next channel is just shifting another one in at the bottom.
  // The vector being all ones afterwards marks the final release.
  assign countInc  = count_q + CNT_ONE;
  assign outsShift = {outs_q, 1'b1};
  assign outsNext  = outsShift[NCH-1:0];

  // Next-state logic. A software request overrides whatever the FSM would
  // otherwise do, including a release due on the same edge, so that channel
  // stays asserted and the sequence starts over from HOLD with a clear count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    outs_d  = outs_q;
    done_d  = done_q;

    if (soft_rst_req) begin
      state_d = HOLD;
      count_d = '0;
      outs_d  = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          outs_d = '0;
          done_d = 1'b0;
          if (rstSync) begin
            if (countInc == HOLD_END) begin
              count_d = '0;
              outs_d  = FIRST_CH;
              if (NCH == 1) begin
                done_d  = 1'b1;
                state_d = DONE;
              end else begin
                state_d = RELEASE;
              end
            end else begin
              count_d = countInc;
            end
          end
        end

        RELEASE: begin
          if (countInc == GAP_END) begin
            count_d = '0;
            outs_d  = outsNext;
            if (&outsNext) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            count_d = countInc;
          end
        end

        DONE: begin
          count_d = '0;
          outs_d  = '1;
          done_d  = 1'b1;
        end

        default: begin
          state_d = HOLD;
          count_d = '0;
          outs_d  = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // All outputs come straight from flops; the only path from an input to an
  // output that bypasses the clock is the asynchronous clear from rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= HOLD;
      count_q <= '0;
      outs_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      outs_q  <= outs_d;
      done_q  <= done_d;
    end
  end

  assign rstn_out = outs_q;
  assign rst_done = done_q;

endmodule
